// File: rtl/alu_op_pkg.sv
// Shared ALU opcode fields, RV32I encodings, decode bundle and FSM states for
// the ALU issue controller and the ALU datapath.
package alu_op_pkg;

  // alu_op[6:4]: result select
  localparam logic [2:0] SEL_ADDSUB = 3'b000;
  localparam logic [2:0] SEL_AND    = 3'b001;
  localparam logic [2:0] SEL_OR     = 3'b010;
  localparam logic [2:0] SEL_XOR    = 3'b011;
  localparam logic [2:0] SEL_SHIFT  = 3'b100;

  // alu_op[3:1]: shift mode (one-hot), alu_op[0]: subtract
  localparam logic [2:0] SH_NONE = 3'b000;
  localparam logic [2:0] SH_SLL  = 3'b001;
  localparam logic [2:0] SH_SRL  = 3'b010;
  localparam logic [2:0] SH_SRA  = 3'b100;
  localparam logic       OP_SUB  = 1'b1;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    BR_TGT = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic        legal;
    logic        is_branch;
    logic        is_slt;
    logic        use_imm;
    logic [31:0] imm;
    logic [6:0]  alu_op;
    logic [4:0]  rd;
  } dec_t;

  function automatic logic [6:0] mk_op(input logic [2:0] sel, input logic [2:0] sh,
                                       input logic sub);
    return {sel, sh, sub};
  endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational RV32I decode: instruction word to ALU opcode, immediate and
// control flags. Only the integer ALU ops and BEQ/BNE/BLT/BGE are legal.
module rv32_alu_decode
  import alu_op_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_imm;
  logic       base_ok;
  logic       unused_rs_fields;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign is_imm  = (opc == OPC_OPIMM);
  // I-type non-shift ops carry immediate bits in the funct7 position
  assign base_ok = is_imm || (f7 == F7_BASE);
  // register numbers are resolved upstream; only the data arrives here
  assign unused_rs_fields = ^instr[19:15];

  // decode table
  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.imm     = {{20{instr[31]}}, instr[31:20]};
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        dec.use_imm = is_imm;
        case (f3)
          F3_ADD: begin
            dec.legal  = base_ok || (f7 == F7_ALT);
            dec.alu_op = mk_op(SEL_ADDSUB, SH_NONE, !is_imm && (f7 == F7_ALT));
          end
          F3_SLL: begin
            dec.legal  = (f7 == F7_BASE);
            dec.imm    = {27'b0, instr[24:20]};
            dec.alu_op = mk_op(SEL_SHIFT, SH_SLL, 1'b0);
          end
          F3_SR: begin
            dec.legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec.imm    = {27'b0, instr[24:20]};
            dec.alu_op = mk_op(SEL_SHIFT, (f7 == F7_ALT) ? SH_SRA : SH_SRL, 1'b0);
          end
          F3_SLT: begin
            dec.legal  = base_ok;
            dec.is_slt = 1'b1;
            dec.alu_op = mk_op(SEL_ADDSUB, SH_NONE, OP_SUB);
          end
          F3_XOR: begin
            dec.legal  = base_ok;
            dec.alu_op = mk_op(SEL_XOR, SH_NONE, 1'b0);
          end
          F3_OR: begin
            dec.legal  = base_ok;
            dec.alu_op = mk_op(SEL_OR, SH_NONE, 1'b0);
          end
          F3_AND: begin
            dec.legal  = base_ok;
            dec.alu_op = mk_op(SEL_AND, SH_NONE, 1'b0);
          end
          default: dec.legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.rd        = '0;
        dec.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.alu_op    = mk_op(SEL_ADDSUB, SH_NONE, OP_SUB);
        dec.legal     = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue controller: accepts an RV32I bundle, drives the external
// ALU for one (ALU op) or two (branch) cycles and returns the response.
module alu_issue_ctrl
  import alu_op_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [SIZE-1:0] in_pc,
  input  logic [SIZE-1:0] in_rs1_data,
  input  logic [SIZE-1:0] in_rs2_data,
  output logic [SIZE-1:0] alu_operand1,
  output logic [SIZE-1:0] alu_operand2,
  output logic [6:0]      alu_op,
  input  logic [SIZE-1:0] alu_result,
  input  logic            alu_eq,
  input  logic            alu_gt,
  input  logic            alu_lt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_we,
  output logic [SIZE-1:0] out_rd_data,
  output logic            out_br_taken,
  output logic [SIZE-1:0] out_br_target,
  output logic            out_illegal
);

  state_t          state, state_n;
  dec_t            dec;
  logic            is_branch_q, is_slt_q;
  logic [6:0]      alu_op_q;
  logic [2:0]      f3_q;
  logic [SIZE-1:0] pc_q, op1_q, op2_q, bimm_q;
  logic            br_cond;
  logic            unused_gt;

  // branch conditions only need eq/lt; gt is part of the ALU contract
  assign unused_gt = alu_gt;

  rv32_alu_decode u_dec (.instr(in_instr), .dec(dec));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state, handshakes and ALU drive
  always_comb begin
    state_n      = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    alu_op       = '0;
    alu_operand1 = '0;
    alu_operand2 = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = dec.legal ? EXEC : RESP;
      end
      EXEC: begin
        alu_op       = alu_op_q;
        alu_operand1 = op1_q;
        alu_operand2 = op2_q;
        state_n      = is_branch_q ? BR_TGT : RESP;
      end
      BR_TGT: begin
        alu_op       = mk_op(SEL_ADDSUB, SH_NONE, 1'b0);
        alu_operand1 = pc_q;
        alu_operand2 = bimm_q;
        state_n      = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // branch condition from comparator flags of rs1 vs rs2
  always_comb begin
    br_cond = 1'b0;
    case (f3_q)
      F3_BEQ:  br_cond = alu_eq;
      F3_BNE:  br_cond = !alu_eq;
      F3_BLT:  br_cond = alu_lt;
      F3_BGE:  br_cond = !alu_lt;
      default: br_cond = 1'b0;
    endcase
  end

  // operand latch on accept and response capture; out_* only change
  // outside RESP so they stay stable under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      is_branch_q   <= 1'b0;
      is_slt_q      <= 1'b0;
      alu_op_q      <= '0;
      f3_q          <= '0;
      pc_q          <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      bimm_q        <= '0;
      out_rd_addr   <= '0;
      out_rd_we     <= 1'b0;
      out_rd_data   <= '0;
      out_br_taken  <= 1'b0;
      out_br_target <= '0;
      out_illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          is_branch_q   <= dec.is_branch;
          is_slt_q      <= dec.is_slt;
          alu_op_q      <= dec.alu_op;
          f3_q          <= in_instr[14:12];
          pc_q          <= in_pc;
          op1_q         <= in_rs1_data;
          bimm_q        <= dec.imm;
          if (dec.use_imm)                   op2_q <= dec.imm;
          else if (dec.alu_op[6:4] == SEL_SHIFT) op2_q <= {{(SIZE-5){1'b0}}, in_rs2_data[4:0]};
          else                               op2_q <= in_rs2_data;
          out_rd_addr   <= (dec.legal && !dec.is_branch) ? dec.rd : '0;
          out_rd_we     <= dec.legal && !dec.is_branch && (dec.rd != '0);
          out_illegal   <= !dec.legal;
          out_rd_data   <= '0;
          out_br_taken  <= 1'b0;
          out_br_target <= '0;
        end
        EXEC: begin
          if (is_branch_q)   out_br_taken <= br_cond;
          else if (is_slt_q) out_rd_data  <= {{(SIZE-1){1'b0}}, alu_lt};
          else               out_rd_data  <= alu_result;
        end
        BR_TGT: out_br_target <= alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the ALU port, directed cases
// and a randomized run checked against an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic [31:0] alu_operand1, alu_operand2, alu_result;
  logic [6:0]  alu_op;
  logic        alu_eq, alu_gt, alu_lt;
  logic        out_valid, out_ready = 1'b0;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we, out_br_taken, out_illegal;
  logic [31:0] out_rd_data, out_br_target;

  int n_cmp = 0, n_err = 0;
  logic [6:0]  exec_op;
  logic [31:0] exec_op2;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SIZE(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_addr(out_rd_addr),
    .out_rd_we(out_rd_we), .out_rd_data(out_rd_data), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target), .out_illegal(out_illegal)
  );

  // behavioural ALU
  always_comb begin
    alu_result = '0;
    case (alu_op[6:4])
      3'd0: alu_result = alu_op[0] ? alu_operand1 - alu_operand2 : alu_operand1 + alu_operand2;
      3'd1: alu_result = alu_operand1 & alu_operand2;
      3'd2: alu_result = alu_operand1 | alu_operand2;
      3'd3: alu_result = alu_operand1 ^ alu_operand2;
      3'd4: case (alu_op[3:1])
        3'b001:  alu_result = alu_operand1 << alu_operand2[4:0];
        3'b010:  alu_result = alu_operand1 >> alu_operand2[4:0];
        3'b100:  alu_result = 32'($signed(alu_operand1) >>> alu_operand2[4:0]);
        default: alu_result = '0;
      endcase
      default: alu_result = '0;
    endcase
  end
  assign alu_eq = (alu_operand1 == alu_operand2);
  assign alu_lt = ($signed(alu_operand1) < $signed(alu_operand2));
  assign alu_gt = ($signed(alu_operand1) > $signed(alu_operand2));

  typedef struct packed {
    bit        legal;
    bit        branch;
    bit        we;
    bit [4:0]  rd;
    bit [31:0] data;
    bit        taken;
    bit [31:0] target;
    int        lat;
  } exp_t;

  // instruction-level reference: what the architectural result should be
  function automatic exp_t model(input bit [31:0] i, input bit [31:0] pc,
                                 input bit [31:0] a, input bit [31:0] b);
    exp_t e;
    bit [6:0] opc = i[6:0], f7 = i[31:25];
    bit [2:0] f3 = i[14:12];
    bit r = (opc == 7'b0110011);
    bit [31:0] iv = {{20{i[31]}}, i[31:20]};
    bit [31:0] bv = r ? b : iv;
    bit [4:0]  sh = r ? b[4:0] : i[24:20];
    bit ok7 = !r || f7 == 7'h00;
    bit [31:0] boff = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    e = '0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      case (f3)
        3'b000: if (!r)               begin e.legal = 1; e.data = a + bv; end
                else if (f7 == 7'h00) begin e.legal = 1; e.data = a + b; end
                else if (f7 == 7'h20) begin e.legal = 1; e.data = a - b; end
        3'b001: if (f7 == 7'h00) begin e.legal = 1; e.data = a << sh; end
        3'b101: if (f7 == 7'h00) begin e.legal = 1; e.data = a >> sh; end
                else if (f7 == 7'h20) begin e.legal = 1; e.data = 32'($signed(a) >>> sh); end
        3'b010: if (ok7) begin e.legal = 1; e.data = ($signed(a) < $signed(bv)) ? 1 : 0; end
        3'b100: if (ok7) begin e.legal = 1; e.data = a ^ bv; end
        3'b110: if (ok7) begin e.legal = 1; e.data = a | bv; end
        3'b111: if (ok7) begin e.legal = 1; e.data = a & bv; end
        default: ;
      endcase
      if (e.legal) begin e.rd = i[11:7]; e.we = (i[11:7] != 0); e.lat = 2; end
    end else if (opc == 7'b1100011) begin
      e.branch = 1;
      e.target = pc + boff;
      case (f3)
        3'b000: begin e.legal = 1; e.taken = (a == b); end
        3'b001: begin e.legal = 1; e.taken = (a != b); end
        3'b100: begin e.legal = 1; e.taken = ($signed(a) < $signed(b)); end
        3'b101: begin e.legal = 1; e.taken = ($signed(a) >= $signed(b)); end
        default: ;
      endcase
      if (e.legal) e.lat = 3;
    end
    if (!e.legal) begin e = '0; e.lat = 1; end
    return e;
  endfunction

  // drive one bundle and wait for out_valid; out_ready stays low
  task automatic issue(input logic [31:0] ins, pc, a, b, output int lat, output bit to);
    int g = 0;
    to = 0; lat = 0;
    @(negedge clk);
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    if (!in_ready) begin to = 1; return; end
    in_valid = 1; in_instr = ins; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
    @(posedge clk); #1 in_valid = 0;
    lat = 1;
    @(negedge clk);
    exec_op = alu_op; exec_op2 = alu_operand2;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    if (!out_valid) to = 1;
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_rd_we, out_illegal, out_br_taken, out_rd_addr} !== 8'h0) begin n_err++; $display("FAIL rst_flags got %h want 0", {out_rd_we, out_illegal, out_br_taken, out_rd_addr}); end
    n_cmp++; if ({out_rd_data, out_br_target} !== 64'h0) begin n_err++; $display("FAIL rst_data got %h want 0", {out_rd_data, out_br_target}); end
    n_cmp++; if ({alu_op, alu_operand1, alu_operand2} !== 71'h0) begin n_err++; $display("FAIL rst_alu got %h want 0", {alu_op, alu_operand1, alu_operand2}); end
    rst = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_alu_ops();
    int lat; bit to;
    issue(32'h002081B3, 32'h40, 32'd5, 32'd7, lat, to);
    n_cmp++; if (to || lat != 2) begin n_err++; $display("FAIL add_lat got %0d want 2", lat); end
    n_cmp++; if (exec_op !== 7'h00) begin n_err++; $display("FAIL add_op got %h want 00", exec_op); end
    n_cmp++; if ({out_rd_addr, out_rd_we, out_illegal} !== {5'd3, 1'b1, 1'b0}) begin n_err++; $display("FAIL add_rd got %h want %h", {out_rd_addr, out_rd_we, out_illegal}, {5'd3, 2'b10}); end
    n_cmp++; if (out_rd_data !== 32'd12) begin n_err++; $display("FAIL add_data got %h want 0000000c", out_rd_data); end
    handshake();
    issue(32'h402081B3, 32'h44, 32'd5, 32'd7, lat, to);
    n_cmp++; if (exec_op[0] !== 1'b1) begin n_err++; $display("FAIL sub_op got %h want sub bit", exec_op); end
    n_cmp++; if (out_rd_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub_data got %h want fffffffe", out_rd_data); end
    handshake();
    issue(32'h4040D193, 32'h48, 32'h80000000, 32'h0, lat, to);
    n_cmp++; if (exec_op !== 7'h48 || exec_op2 !== 32'd4) begin n_err++; $display("FAIL srai_op got %h/%h want 48/4", exec_op, exec_op2); end
    n_cmp++; if (out_rd_data !== 32'hF8000000) begin n_err++; $display("FAIL srai_data got %h want f8000000", out_rd_data); end
    handshake();
  endtask

  task automatic test_branch();
    int lat; bit to;
    issue(32'h00208863, 32'h100, 32'd9, 32'd9, lat, to);
    n_cmp++; if (to || lat != 3) begin n_err++; $display("FAIL beq_lat got %0d want 3", lat); end
    n_cmp++; if ({out_br_taken, out_rd_we} !== 2'b10) begin n_err++; $display("FAIL beq_taken got %b want 10", {out_br_taken, out_rd_we}); end
    n_cmp++; if (out_br_target !== 32'h110) begin n_err++; $display("FAIL beq_target got %h want 110", out_br_target); end
    handshake();
    issue(32'h00208863, 32'h100, 32'd9, 32'd8, lat, to);
    n_cmp++; if (out_br_taken !== 1'b0 || out_br_target !== 32'h110) begin n_err++; $display("FAIL beq_nt got %b/%h want 0/110", out_br_taken, out_br_target); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat; bit to; logic [71:0] snap; bit stable = 1, rdy_lo = 1;
    issue(32'h0020C1B3, 32'h200, 32'hA5A5_0F0F, 32'h0FF0_FF00, lat, to); // XOR x3,x1,x2
    snap = {out_rd_addr, out_rd_we, out_rd_data, out_br_taken, out_br_target, out_illegal, out_valid};
    repeat (4) begin
      @(negedge clk);
      if ({out_rd_addr, out_rd_we, out_rd_data, out_br_taken, out_br_target, out_illegal, out_valid} !== snap) stable = 0;
      if (in_ready !== 1'b0) rdy_lo = 0;
    end
    n_cmp++; if (!stable || out_rd_data !== 32'hAA55_F00F) begin n_err++; $display("FAIL bp_stable got %h want aa55f00f held", out_rd_data); end
    n_cmp++; if (!rdy_lo) begin n_err++; $display("FAIL bp_in_ready got 1 want 0 during RESP"); end
    handshake();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    in_valid = 1; in_instr = 32'h0020F1B3; in_rs1_data = 32'hF0F0; in_rs2_data = 32'h0FF0; // AND
    @(posedge clk); #1 in_valid = 0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept got in_ready=%b want 0", in_ready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_rd_data !== 32'h00F0) begin n_err++; $display("FAIL bp_next got %b/%h want 1/000000f0", out_valid, out_rd_data); end
    handshake();
  endtask

  task automatic test_illegal();
    int lat; bit to;
    issue(32'h0, 32'h300, 32'd1, 32'd2, lat, to);
    n_cmp++; if (to || lat != 1) begin n_err++; $display("FAIL ill_lat got %0d want 1", lat); end
    n_cmp++; if ({out_illegal, out_rd_we} !== 2'b10) begin n_err++; $display("FAIL ill_flags got %b want 10", {out_illegal, out_rd_we}); end
    handshake();
    issue(32'h022081B3, 32'h304, 32'd1, 32'd2, lat, to); // ADD with funct7=0000001
    n_cmp++; if (lat != 1 || out_illegal !== 1'b1) begin n_err++; $display("FAIL ill_f7 got lat=%0d ill=%b want 1/1", lat, out_illegal); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    in_valid = 1; in_instr = 32'h002081B3; in_rs1_data = 32'd1; in_rs2_data = 32'd2;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_state got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    repeat (4) begin @(negedge clk); if (out_valid) seen++; end
    n_cmp++; if (seen != 0 || out_rd_data !== 32'h0) begin n_err++; $display("FAIL rmid_noresp got %0d responses data=%h want 0", seen, out_rd_data); end
  endtask

  task automatic test_random();
    int lat; bit to; exp_t e;
    logic [31:0] ins, pc, a, b;
    logic [6:0]  f7;
    for (int n = 0; n < 80; n++) begin
      f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h00 : 7'h20);
      ins = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ins = {f7, ins[24:7], 7'b0110011};
        4, 5, 6:    ins = {(ins[13:12] == 2'b01) ? f7 : ins[31:25], ins[24:7], 7'b0010011};
        7, 8:       ins = {ins[31:7], 7'b1100011};
        default: ;
      endcase
      pc = {$urandom} & 32'hFFFF_FFFC;
      a  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
      b  = $urandom_range(0, 3) == 0 ? a : $urandom;
      e  = model(ins, pc, a, b);
      issue(ins, pc, a, b, lat, to);
      n_cmp++; if (to || lat != e.lat) begin n_err++; $display("FAIL rnd_lat %h got %0d want %0d", ins, lat, e.lat); end
      n_cmp++; if ({out_illegal, out_rd_we} !== {!e.legal, e.we}) begin n_err++; $display("FAIL rnd_flags %h got %b want %b", ins, {out_illegal, out_rd_we}, {!e.legal, e.we}); end
      if (e.legal && !e.branch) begin
        n_cmp++; if (out_rd_data !== e.data || out_rd_addr !== e.rd) begin n_err++; $display("FAIL rnd_data %h got %h/x%0d want %h/x%0d", ins, out_rd_data, out_rd_addr, e.data, e.rd); end
      end
      n_cmp++; if ({out_br_taken, out_br_target} !== {e.taken, e.target}) begin n_err++; $display("FAIL rnd_br %h got %b/%h want %b/%h", ins, out_br_taken, out_br_target, e.taken, e.target); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
